tx_ingress: RTL and testbench
=============================

// Module: tx_ingress
// PURPOSE
//  Upstream feeder for the tx block. Accepts 6-bit words from a host over a valid/ready
//  handshake and buffers them in a small FIFO. Drives PUSH_MAIN/DATA_IN_TX into the tx main
//  FIFO under MAIN_PAUSE back-pressure. Sequences the tx init pulse and holds the main-FIFO
//  thresholds stable.
// PARAMETERS
//  DATA_W   6   word width; matches DATA_IN_TX
//  BUF_D    4   skid buffer depth (power of 2)
//  PTR_W    2   log2(BUF_D)
//  CNT_W    16  width of pushed-word counter
// PORTS
//  clk             in   1       single clock; all logic on posedge
//  RESET           in   1       synchronous, active-high reset
//  in_valid        in   1       host word valid
//  in_data         in   DATA_W  host word
//  in_ready        out  1       block can accept in_data this cycle
//  cfg_start       in   1       request (re)configuration of tx thresholds
//  cfg_low         in   5       main FIFO almost-empty threshold to load
//  cfg_high        in   5       main FIFO almost-full threshold to load
//  MAIN_PAUSE      in   1       from tx; 1 = do not push this cycle
//  PUSH_MAIN       out  1       push strobe to tx main FIFO (registered)
//  DATA_IN_TX      out  DATA_W  word to tx main FIFO (registered)
//  init            out  1       one-cycle init pulse to tx (registered)
//  main_fifo_low   out  5       latched low threshold
//  main_fifo_high  out  5       latched high threshold
//  busy            out  1       buffer non-empty or state != RUN/IDLE
//  pushed_cnt      out  CNT_W   words pushed since reset; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (RESET=1 at posedge): state=IDLE; buffer emptied; all outputs 0, including
//  in_ready, PUSH_MAIN, DATA_IN_TX, init, thresholds and pushed_cnt. Reset overrides
//  everything mid-operation; buffered words are discarded.
//  FSM:
//   IDLE  - in_ready=0. On cfg_start go to CFG.
//   CFG   - lasts exactly 1 cycle. Latch cfg_low/cfg_high into the threshold outputs on
//           entry edge. init=1 during this cycle. Then go to RUN.
//   RUN   - in_ready = !full. On cfg_start go to DRAIN; a word accepted in the same cycle
//           is kept.
//   DRAIN - in_ready=0. Keep pushing. When buffer empty and no push in flight, go to CFG.
//  cfg_start in CFG or DRAIN is ignored.
//  Accept: write in_data when in_valid & in_ready; occupancy +1.
//  Push: in RUN or DRAIN, if buffer non-empty & MAIN_PAUSE==0 at the edge, pop the head.
//   Next cycle PUSH_MAIN=1 and DATA_IN_TX=head; otherwise PUSH_MAIN=0 and DATA_IN_TX holds.
//   At most one push per cycle.
//  Latency: a word accepted at edge N is visible on PUSH_MAIN/DATA_IN_TX at the earliest
//   after edge N+1 (2-cycle min), when the buffer was empty and MAIN_PAUSE=0.
//  Simultaneous accept + pop: both happen; occupancy unchanged. Accept is blocked only when
//   full at cycle start, even if a pop occurs that cycle.
//  Full: occupancy==BUF_D forces in_ready=0. Empty: no push.
//  Pointers: PTR_W bits wrap naturally. Occupancy is PTR_W+1 bits, range 0..BUF_D.
//  Order: strict FIFO; no word is dropped or duplicated.
//  pushed_cnt increments on each cycle PUSH_MAIN=1.
//  busy = (occupancy!=0) | PUSH_MAIN | (state==CFG) | (state==DRAIN).
// TESTING
//  T1 reset: assert RESET 2 cycles mid-traffic -> all outputs 0 and occupancy 0 next cycle.
//  T2 cfg: cfg_start=1, cfg_low=2, cfg_high=12 in IDLE -> one-cycle init=1, thresholds=2/12,
//     then in_ready=1.
//  T3 stream: send 0x01..0x08 back-to-back with MAIN_PAUSE=0 -> PUSH_MAIN pulses 8 times,
//     data in order, first push 2 cycles after accept, pushed_cnt=8.
//  T4 pause/full: MAIN_PAUSE=1, send 6 words -> in_ready drops after 4, no push. Release
//     MAIN_PAUSE -> words 1..6 pushed in order.
//  T5 reconfig: cfg_start during RUN with 3 words buffered -> in_ready=0, 3 pushes, then
//     init pulse and new thresholds, then RUN.
//  T6 counter wrap: preload/force pushed_cnt=0xFFFF, one push -> pushed_cnt=0x0000.

Source files
------------

// File: rtl/tx_ingress.sv
// tx_ingress: host-side feeder for the tx block. Buffers host words in a small FIFO,
// pushes them into the tx main FIFO under MAIN_PAUSE back-pressure, sequences the tx
// init pulse and holds the main-FIFO thresholds stable between reconfigurations.
module tx_ingress #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned BUF_D  = 4,
  parameter int unsigned PTR_W  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              cfg_start,
  input  logic [4:0]        cfg_low,
  input  logic [4:0]        cfg_high,
  input  logic              MAIN_PAUSE,
  output logic              PUSH_MAIN,
  output logic [DATA_W-1:0] DATA_IN_TX,
  output logic              init,
  output logic [4:0]        main_fifo_low,
  output logic [4:0]        main_fifo_high,
  output logic              busy,
  output logic [CNT_W-1:0]  pushed_cnt
);

  typedef enum logic [1:0] {StIdle, StCfg, StRun, StDrain} state_e;

  localparam logic [PTR_W:0] OccFull = (PTR_W+1)'(BUF_D);

  state_e              r_state;
  state_e              w_state_d;

  logic [DATA_W-1:0]   r_mem [BUF_D];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_occ;
  logic                r_push;
  logic [DATA_W-1:0]   r_data;
  logic                r_init;
  logic [4:0]          r_low;
  logic [4:0]          r_high;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_full;
  logic                w_empty;
  logic                w_in_ready;
  logic                w_pop_en;
  logic                w_accept;
  logic                w_pop;

  assign w_full   = (r_occ == OccFull);
  assign w_empty  = (r_occ == '0);
  // Full is judged on start-of-cycle occupancy, so a same-cycle pop never frees a slot.
  assign w_accept = in_valid & w_in_ready;
  assign w_pop    = w_pop_en & ~w_empty & ~MAIN_PAUSE;

  // State register.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; cfg_start is only honoured in IDLE and RUN.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (cfg_start) w_state_d = StCfg;
      StCfg:   w_state_d = StRun;
      StRun:   if (cfg_start) w_state_d = StDrain;
      // Wait for the last pushed word to leave PUSH_MAIN before re-initialising tx.
      StDrain: if (w_empty && !r_push) w_state_d = StCfg;
      default: w_state_d = StIdle;
    endcase
  end

  // State-decoded outputs: host acceptance and pop permission.
  always_comb begin
    w_in_ready = 1'b0;
    w_pop_en   = 1'b0;
    unique case (r_state)
      StRun: begin
        w_in_ready = ~w_full;
        w_pop_en   = 1'b1;
      end
      StDrain: w_pop_en = 1'b1;
      default: ;
    endcase
  end

  // Buffer storage; stale entries are harmless because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_accept && !w_pop) begin
        r_occ <= r_occ + (PTR_W+1)'(1);
      end else if (!w_accept && w_pop) begin
        r_occ <= r_occ - (PTR_W+1)'(1);
      end
    end
  end

  // Registered push strobe and data to the tx main FIFO; data holds between pushes.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_push <= 1'b0;
      r_data <= '0;
    end else begin
      r_push <= w_pop;
      if (w_pop) r_data <= r_mem[r_rd_ptr];
    end
  end

  // Init pulse and threshold latch, both taken on the edge that enters CFG.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_init <= 1'b0;
      r_low  <= '0;
      r_high <= '0;
    end else begin
      r_init <= (w_state_d == StCfg);
      if (w_state_d == StCfg && r_state != StCfg) begin
        r_low  <= cfg_low;
        r_high <= cfg_high;
      end
    end
  end

  // Pushed-word counter: counts each cycle PUSH_MAIN is high, wrapping naturally.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (r_push) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready       = w_in_ready;
  assign PUSH_MAIN      = r_push;
  assign DATA_IN_TX     = r_data;
  assign init           = r_init;
  assign main_fifo_low  = r_low;
  assign main_fifo_high = r_high;
  assign pushed_cnt     = r_cnt;
  assign busy           = ~w_empty | r_push | (r_state == StCfg) | (r_state == StDrain);

endmodule

// File: tb/tb_tx_ingress.sv
// Scoreboard bench for tx_ingress: accepted words are queued as expectations and a
// negedge monitor compares each PUSH_MAIN beat against the queue head.
module tb_tx_ingress;

  logic        clk;
  logic        RESET;
  logic        in_valid;
  logic [5:0]  in_data;
  logic        in_ready;
  logic        cfg_start;
  logic [4:0]  cfg_low;
  logic [4:0]  cfg_high;
  logic        MAIN_PAUSE;
  logic        PUSH_MAIN;
  logic [5:0]  DATA_IN_TX;
  logic        init;
  logic [4:0]  main_fifo_low;
  logic [4:0]  main_fifo_high;
  logic        busy;
  logic [15:0] pushed_cnt;

  int          checks = 0;
  int          errors = 0;
  int          wn;
  logic [5:0]  exp_q[$];
  logic [5:0]  mon_exp;

  tx_ingress #(
    .DATA_W(6),
    .BUF_D (4),
    .PTR_W (2),
    .CNT_W (16)
  ) dut (
    .clk           (clk),
    .RESET         (RESET),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .cfg_start     (cfg_start),
    .cfg_low       (cfg_low),
    .cfg_high      (cfg_high),
    .MAIN_PAUSE    (MAIN_PAUSE),
    .PUSH_MAIN     (PUSH_MAIN),
    .DATA_IN_TX    (DATA_IN_TX),
    .init          (init),
    .main_fifo_low (main_fifo_low),
    .main_fifo_high(main_fifo_high),
    .busy          (busy),
    .pushed_cnt    (pushed_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every push beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (PUSH_MAIN === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL push_unexpected: got data=%0h, required no push", DATA_IN_TX);
      end else begin
        mon_exp = exp_q.pop_front();
        if (DATA_IN_TX !== mon_exp) begin
          errors++;
          $display("FAIL push_data: got %0h, required %0h", DATA_IN_TX, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Present one word and hold it until accepted; the expectation is queued on acceptance.
  task automatic send(input logic [5:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end else begin
      exp_q.push_back(d);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || PUSH_MAIN === 1'b1) && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    RESET      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    cfg_start  = 1'b0;
    cfg_low    = '0;
    cfg_high   = '0;
    MAIN_PAUSE = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_push", PUSH_MAIN, 0);
    chk("rst_data", DATA_IN_TX, 0);
    chk("rst_init", init, 0);
    chk("rst_low", main_fifo_low, 0);
    chk("rst_high", main_fifo_high, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", pushed_cnt, 0);
    RESET = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 0);

    // T2: configuration from IDLE
    cfg_start = 1'b1;
    cfg_low   = 5'd2;
    cfg_high  = 5'd12;
    tick();
    cfg_start = 1'b0;
    cfg_low   = 5'd0;
    cfg_high  = 5'd0;
    chk("t2_init", init, 1);
    chk("t2_low", main_fifo_low, 2);
    chk("t2_high", main_fifo_high, 12);
    chk("t2_cfg_ready", in_ready, 0);
    chk("t2_cfg_busy", busy, 1);
    tick();
    chk("t2_init_off", init, 0);
    chk("t2_run_ready", in_ready, 1);
    chk("t2_low_hold", main_fifo_low, 2);
    chk("t2_high_hold", main_fifo_high, 12);

    // T3: back-to-back stream, two-cycle minimum latency
    send(6'h01);
    chk("t3_lat_edge1", PUSH_MAIN, 0);
    send(6'h02);
    chk("t3_lat_edge2", PUSH_MAIN, 1);
    chk("t3_first_data", DATA_IN_TX, 6'h01);
    for (int k = 3; k <= 8; k++) send(6'(k));
    wait_drain("t3");
    chk("t3_cnt", pushed_cnt, 8);
    chk("t3_idle_busy", busy, 0);
    chk("t3_data_hold", DATA_IN_TX, 6'h08);

    // T4: pause fills the buffer, release drains in order
    MAIN_PAUSE = 1'b1;
    for (int k = 0; k < 4; k++) send(6'h11 + 6'(k));
    in_valid = 1'b1;
    in_data  = 6'h15;
    chk("t4_full_ready", in_ready, 0);
    chk("t4_full_busy", busy, 1);
    repeat (3) tick();
    chk("t4_paused_nopush", PUSH_MAIN, 0);
    chk("t4_still_full", in_ready, 0);
    MAIN_PAUSE = 1'b0;
    tick();
    chk("t4_ready_after_pop", in_ready, 1);
    chk("t4_first_push", PUSH_MAIN, 1);
    send(6'h15);
    send(6'h16);
    wait_drain("t4");
    chk("t4_cnt", pushed_cnt, 14);

    // T5: reconfiguration while words are buffered; same-cycle word is kept
    MAIN_PAUSE = 1'b1;
    send(6'h21);
    send(6'h22);
    send(6'h23);
    cfg_start = 1'b1;
    cfg_low   = 5'd5;
    cfg_high  = 5'd20;
    in_valid  = 1'b1;
    in_data   = 6'h24;
    chk("t5_ready_at_cfg", in_ready, 1);
    exp_q.push_back(6'h24);
    tick();
    in_valid = 1'b0;
    chk("t5_drain_ready", in_ready, 0);
    chk("t5_drain_busy", busy, 1);
    chk("t5_drain_low", main_fifo_low, 2);
    chk("t5_drain_high", main_fifo_high, 12);
    tick();
    cfg_start = 1'b0;
    chk("t5_drain_no_init", init, 0);
    MAIN_PAUSE = 1'b0;
    wn = 0;
    while (init !== 1'b1 && wn < 50) begin
      tick();
      wn++;
    end
    chk("t5_init", init, 1);
    chk("t5_all_pushed", exp_q.size(), 0);
    chk("t5_no_push_at_init", PUSH_MAIN, 0);
    chk("t5_low", main_fifo_low, 5);
    chk("t5_high", main_fifo_high, 20);
    cfg_low  = 5'd0;
    cfg_high = 5'd0;
    tick();
    chk("t5_init_off", init, 0);
    chk("t5_run_ready", in_ready, 1);
    chk("t5_low_hold", main_fifo_low, 5);
    chk("t5_cnt", pushed_cnt, 18);

    // T6: counter wrap
    force dut.r_cnt = 16'hFFFF;
    tick();
    release dut.r_cnt;
    tick();
    chk("t6_preload", pushed_cnt, 16'hFFFF);
    send(6'h3F);
    wait_drain("t6");
    chk("t6_wrap", pushed_cnt, 16'h0000);

    // T1: reset mid-traffic discards buffered words
    MAIN_PAUSE = 1'b1;
    send(6'h31);
    send(6'h32);
    in_valid = 1'b1;
    in_data  = 6'h33;
    RESET    = 1'b1;
    tick();
    tick();
    exp_q.delete();
    chk("t1_in_ready", in_ready, 0);
    chk("t1_push", PUSH_MAIN, 0);
    chk("t1_data", DATA_IN_TX, 0);
    chk("t1_init", init, 0);
    chk("t1_low", main_fifo_low, 0);
    chk("t1_high", main_fifo_high, 0);
    chk("t1_busy", busy, 0);
    chk("t1_cnt", pushed_cnt, 0);
    RESET      = 1'b0;
    in_valid   = 1'b0;
    MAIN_PAUSE = 1'b0;
    repeat (3) tick();
    chk("t1_after_push", PUSH_MAIN, 0);
    chk("t1_after_busy", busy, 0);
    chk("t1_after_ready", in_ready, 0);

    chk("end_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
